// File: rtl/byte_join_pkg.sv
// rtl/byte_join_pkg.sv - shared width-mode constants and lane slicing helpers for the byte joiner
package byte_join_pkg;

   localparam int WIDTH_X1 = 0;
   localparam int WIDTH_X2 = 1;
   localparam int WIDTH_X4 = 3;
   localparam int WIDTH_X8 = 7;

   function automatic int sel_width(input int num_lanes);
      return (num_lanes > 1) ? $clog2(num_lanes) : 1;
   endfunction

   // Bit offset of a lane symbol within a packed multi-lane word
   function automatic int lane_lsb(input int lane, input int data_w);
      return lane * data_w;
   endfunction

endpackage

// File: rtl/byte_joining_param_if.sv
// rtl/byte_joining_param_if.sv - lane-word input, serial byte output and status bundle of the joiner
interface byte_joining_param_if
   import byte_join_pkg::*;
#(
   parameter int NUM_LANES = 4,
   parameter int DATA_W    = 8
);
   localparam int SEL_W = sel_width(NUM_LANES);

   logic [NUM_LANES*DATA_W-1:0] lanes_in;
   logic                        lanes_valid;
   logic                        lanes_ready;
   logic [SEL_W-1:0]            active_lanes;
   logic [DATA_W-1:0]           data_out;
   logic                        data_valid;
   logic                        out_ready;
   logic [SEL_W-1:0]            lane_sel;
   logic                        cfg_err;

   modport master (
      output lanes_in, lanes_valid, active_lanes, out_ready,
      input  lanes_ready, data_out, data_valid, lane_sel, cfg_err
   );

   modport slave (
      input  lanes_in, lanes_valid, active_lanes, out_ready,
      output lanes_ready, data_out, data_valid, lane_sel, cfg_err
   );

endinterface

// File: rtl/byte_join_buf.sv
// rtl/byte_join_buf.sv - two-entry ping-pong word store carrying a per-entry width tag
module byte_join_buf #(
   parameter int WORD_W = 32,
   parameter int SEL_W  = 2
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              push_i,
   input  logic [WORD_W-1:0] wr_data_i,
   input  logic [SEL_W-1:0]  wr_width_i,
   input  logic              pop_i,
   output logic              full_o,
   output logic              empty_o,
   output logic [WORD_W-1:0] rd_data_o,
   output logic [SEL_W-1:0]  rd_width_o
);

   logic [WORD_W-1:0] data_q  [2];
   logic [SEL_W-1:0]  width_q [2];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q ^ push_i;
      rd_ptr_d = rd_ptr_q ^ pop_i;
      count_d  = count_q + 2'(push_i) - 2'(pop_i);
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload needs no reset: it is only observed while count is nonzero
   always_ff @(posedge clk) begin
      if (push_i) begin
         data_q[wr_ptr_q]  <= wr_data_i;
         width_q[wr_ptr_q] <= wr_width_i;
      end
   end

   assign full_o     = count_q[1];
   assign empty_o    = (count_q == 2'd0);
   assign rd_data_o  = data_q[rd_ptr_q];
   assign rd_width_o = width_q[rd_ptr_q];

endmodule

// File: rtl/byte_joining_param.sv
// rtl/byte_joining_param.sv - serialises NUM_LANES-wide lane words into a byte stream, lane 0 first
module byte_joining_param
   import byte_join_pkg::*;
#(
   parameter int NUM_LANES = 4,
   parameter int DATA_W    = 8,
   parameter int SEL_W     = sel_width(NUM_LANES)
) (
   input logic                 clk,
   input logic                 reset_L,
   byte_joining_param_if.slave bus
);

   localparam int              WORD_W  = NUM_LANES * DATA_W;
   localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_LANES - 1);

   logic              push, pop, full, empty;
   logic [WORD_W-1:0] rd_data;
   logic [SEL_W-1:0]  rd_width;
   logic              width_illegal;
   logic [SEL_W-1:0]  width_clamped;
   logic [SEL_W-1:0]  lane_sel_q, lane_sel_d;
   logic              cfg_err_q, cfg_err_d;
   logic              last_byte;
   logic [DATA_W-1:0] lane_arr [NUM_LANES];

   always_comb begin
      width_illegal = (bus.active_lanes > MAX_SEL);
      width_clamped = width_illegal ? MAX_SEL : bus.active_lanes;
   end

   assign push      = bus.lanes_valid && !full;
   assign last_byte = (lane_sel_q >= rd_width);
   assign pop       = !empty && bus.out_ready && last_byte;

   byte_join_buf #(
      .WORD_W (WORD_W),
      .SEL_W  (SEL_W)
   ) u_buf (
      .clk        (clk),
      .reset_L    (reset_L),
      .push_i     (push),
      .wr_data_i  (bus.lanes_in),
      .wr_width_i (width_clamped),
      .pop_i      (pop),
      .full_o     (full),
      .empty_o    (empty),
      .rd_data_o  (rd_data),
      .rd_width_o (rd_width)
   );

   always_comb begin
      lane_sel_d = lane_sel_q;
      if (!empty && bus.out_ready) begin
         lane_sel_d = last_byte ? '0 : lane_sel_q + SEL_W'(1);
      end
      cfg_err_d = cfg_err_q | (push & width_illegal);
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         lane_sel_q <= '0;
         cfg_err_q  <= 1'b0;
      end else begin
         lane_sel_q <= lane_sel_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_arr[i] = rd_data[lane_lsb(i, DATA_W) +: DATA_W];
      end
   end

   // Zero-gated so an empty buffer never exposes stale payload
   assign bus.data_out    = empty ? '0 : lane_arr[lane_sel_q];
   assign bus.data_valid  = !empty;
   assign bus.lanes_ready = !full;
   assign bus.lane_sel    = lane_sel_q;
   assign bus.cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_byte_joining_param.sv
// tb/tb_byte_joining_param.sv - randomized and directed bench for byte_joining_param against a word-queue model
module tb_byte_joining_param;
   import byte_join_pkg::*;

   localparam int NL = 4;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic reset_L = 1'b0;
   always #5 clk = ~clk;

   byte_joining_param_if #(.NUM_LANES(NL), .DATA_W(DW)) bus ();

   byte_joining_param #(.NUM_LANES(NL), .DATA_W(DW)) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .bus     (bus)
   );

   typedef struct {
      logic [NL*DW-1:0] d;
      int               w;
   } word_t;

   word_t q[$];
   int    pos;
   bit    cfg_m;
   int    n_vec;
   int    n_miss;

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic [DW-1:0]    eb;
      logic [NL*DW-1:0] wd;
      eb = '0;
      if (q.size() != 0) begin
         wd = q[0].d;
         eb = wd[pos*DW +: DW];
      end
      expect_eq("lanes_ready", 32'(bus.lanes_ready), 32'(q.size() < 2));
      expect_eq("data_valid",  32'(bus.data_valid),  32'(q.size() != 0));
      expect_eq("data_out",    32'(bus.data_out),    32'(eb));
      expect_eq("lane_sel",    32'(bus.lane_sel),    32'(pos));
      expect_eq("cfg_err",     32'(bus.cfg_err),     32'(cfg_m));
   endtask

   task automatic model_update(input logic v, input logic [NL*DW-1:0] d, input int w, input logic r);
      bit    acc;
      word_t nw;
      acc = v && (q.size() < 2);
      if (q.size() != 0 && r) begin
         if (pos < q[0].w) pos++;
         else begin
            pos = 0;
            void'(q.pop_front());
         end
      end
      if (acc) begin
         nw.d = d;
         nw.w = (w > NL - 1) ? NL - 1 : w;
         if (w > NL - 1) cfg_m = 1'b1;
         q.push_back(nw);
      end
   endtask

   task automatic step(input logic v, input logic [NL*DW-1:0] d, input int w, input logic r);
      check_outputs();
      bus.lanes_valid  = v;
      bus.lanes_in     = d;
      bus.active_lanes = w[1:0];
      bus.out_ready    = r;
      @(posedge clk);
      model_update(v, d, w, r);
      @(negedge clk);
   endtask

   function automatic logic [NL*DW-1:0] mk(input int b);
      return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
   endfunction

   initial begin
      int wt[4];
      int k;
      bit will_acc;
      wt = '{WIDTH_X1, WIDTH_X2, WIDTH_X4, 2};
      n_vec = 0;
      n_miss = 0;
      pos = 0;
      cfg_m = 1'b0;
      bus.lanes_valid = 1'b0;
      bus.lanes_in = '0;
      bus.active_lanes = '0;
      bus.out_ready = 1'b0;

      reset_L = 1'b0;
      repeat (2) @(negedge clk);
      check_outputs();
      reset_L = 1'b1;

      // single x4 word, lanes 00 01 02 04
      step(1'b1, 32'h04020100, WIDTH_X4, 1'b1);
      repeat (6) step(1'b0, '0, WIDTH_X4, 1'b1);

      // 16 back-to-back x4 words with lanes_valid held high
      k = 0;
      for (int c = 0; c < 200 && k < 16; c++) begin
         will_acc = (q.size() < 2);
         step(1'b1, mk(4 * k), WIDTH_X4, 1'b1);
         if (will_acc) k++;
      end
      expect_eq("b2b_words_accepted", 32'(k), 32'd16);
      repeat (10) step(1'b0, '0, WIDTH_X4, 1'b1);

      // width change between consecutive words
      step(1'b1, 32'hA3A2A1A0, WIDTH_X4, 1'b1);
      step(1'b1, 32'hB3B2B1B0, WIDTH_X2, 1'b1);
      repeat (8) step(1'b0, '0, WIDTH_X4, 1'b1);

      // stall at lane_sel=2 while further words arrive
      step(1'b1, 32'hC3C2C1C0, WIDTH_X4, 1'b1);
      step(1'b0, '0, WIDTH_X4, 1'b1);
      step(1'b0, '0, WIDTH_X4, 1'b1);
      expect_eq("stall_start_lane", 32'(bus.lane_sel), 32'd2);
      for (int i = 0; i < 5; i++) step(1'b1, mk(16 * i + 64), WIDTH_X4, 1'b0);
      repeat (16) step(1'b0, '0, WIDTH_X4, 1'b1);

      // x1 mode at full rate
      repeat (20) step(1'b1, $urandom, WIDTH_X1, 1'b1);
      repeat (4) step(1'b0, '0, WIDTH_X1, 1'b1);

      // random traffic, widths and backpressure
      repeat (300) step(1'($urandom % 2), $urandom, wt[$urandom % 4], ($urandom % 4) != 0);
      repeat (20) step(1'b0, '0, WIDTH_X4, 1'b1);

      // asynchronous reset mid-word with a second word buffered
      step(1'b1, 32'hD3D2D1D0, WIDTH_X4, 1'b1);
      step(1'b1, 32'hE3E2E1E0, WIDTH_X4, 1'b1);
      expect_eq("pre_reset_lane", 32'(bus.lane_sel), 32'd1);
      bus.lanes_valid = 1'b0;
      #2 reset_L = 1'b0;
      #1;
      q.delete();
      pos = 0;
      check_outputs();
      @(negedge clk);
      check_outputs();
      reset_L = 1'b1;
      step(1'b1, 32'hF3F2F1F0, WIDTH_X4, 1'b1);
      repeat (6) step(1'b0, '0, WIDTH_X4, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
